vrf_multiport_sb: RTL and testbench

- Parametrised vector register file for the processing-element datapath.
- Features: NUM_RD asynchronous read ports, two synchronous write ports with PPP lane-partial writes generalised to any DATA_WIDTH, per-register pending-write scoreboard, and a sequential clear-on-reset engine.
- Register 0 is hard-wired zero.
- Sits between decode/issue (scoreboard set, reads) and the writeback stage (write ports).

---
 rtl/vrf_multiport_sb.sv | 228 ++++++++++++++++++++++
 tb/tb_vrf_multiport_sb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_multiport_sb.sv
// vrf_multiport_sb -- vector register file for the processing-element datapath.
//
// Holds DEPTH registers of DATA_WIDTH bits. R0 is hard-wired to zero. The file
// provides NUM_RD asynchronous read ports with same-cycle write-through
// bypass. It has two synchronous write ports with PPP lane-partial writes, a
// per-register pending-write scoreboard, and a clear engine that zeroes
// R1..DEPTH-1 one register per cycle after reset.
//
// Data bits are numbered big-endian: lane bit 0 is the MSB, i.e. vector bit
// DATA_WIDTH-1.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   init_busy        high while the clear engine runs (registered)
//   wrX_en/addr/data/ppp   write port X (X = 0, 1); port 1 wins on lane overlap
//   rd_addr          NUM_RD packed read addresses, port k in slice k
//   rd_data          NUM_RD packed read data (bypassed)
//   rd_pending       scoreboard bit per read port, masked by same-cycle writes
//   sb_set_en/addr   mark a register pending when its producer issues
//   pending_vec      full scoreboard (registered); bit 0 is always 0
module vrf_multiport_sb #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD     = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           init_busy,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic [2:0]                     wr0_ppp,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic [2:0]                     wr1_ppp,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_pending,
  input  logic                           sb_set_en,
  input  logic [ADDR_WIDTH-1:0]          sb_set_addr,
  output logic [DEPTH-1:0]               pending_vec
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Lane mask for a PPP code. Big-endian numbering puts lane bit 0 at the
  // vector MSB, so the upper half is 'u' and byte 0 is the top byte.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [2:0] ppp);
    logic [DATA_WIDTH-1:0] m;
    m = DATA_ZERO;
    case (ppp)
      3'b000:  m = {DATA_WIDTH{1'b1}};
      3'b001:  m = {{(DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};
      3'b010:  m = {{(DATA_WIDTH/2){1'b0}}, {(DATA_WIDTH/2){1'b1}}};
      3'b011:  m = {(DATA_WIDTH/16){16'hFF00}};
      3'b100:  m = {(DATA_WIDTH/16){16'h00FF}};
      default: m = DATA_ZERO;
    endcase
    return m;
  endfunction

  // Replace the masked lanes of base with data.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (base & ~mask) | (data & mask);
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   ptr_r, ptr_nxt_s;
  logic                    busy_r, busy_nxt_s;
  logic [DATA_WIDTH-1:0]   mem_r     [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_nxt_s [DEPTH];
  logic [DEPTH-1:0]        pend_r, pend_nxt_s;
  logic                    run_s;
  logic                    wr0_live_s, wr1_live_s, set_live_s;
  logic [DATA_WIDTH-1:0]   mask0_s, mask1_s;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_s;
  logic [NUM_RD-1:0]       rd_pending_s;

  // A write or set is effective only in RUN, to a non-zero address, and not
  // while reset is being applied. An empty-mask write is still "live" so it
  // clears the scoreboard.
  assign run_s      = (state_r == ST_RUN);
  assign wr0_live_s = run_s & ~reset & wr0_en & (wr0_addr != ADDR_ZERO);
  assign wr1_live_s = run_s & ~reset & wr1_en & (wr1_addr != ADDR_ZERO);
  assign set_live_s = run_s & ~reset & sb_set_en & (sb_set_addr != ADDR_ZERO);
  assign mask0_s    = lane_mask(wr0_ppp);
  assign mask1_s    = lane_mask(wr1_ppp);

  // Clear-engine FSM next state: walk the pointer 1..DEPTH-1, then enter RUN.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      ST_INIT: begin
        if (ptr_r == ADDR_LAST) begin
          state_nxt_s = ST_RUN;
          ptr_nxt_s   = ptr_r;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_INIT;
          ptr_nxt_s   = ptr_r + ADDR_WIDTH'(1);
          busy_nxt_s  = 1'b1;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        ptr_nxt_s   = ptr_r;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_INIT;
        ptr_nxt_s   = ADDR_FIRST;
        busy_nxt_s  = 1'b1;
      end
    endcase
  end

  // Clear-engine FSM state register; reset restarts the sweep from R1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
      ptr_r   <= ADDR_FIRST;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next register contents: clear sweep in INIT, merged port 0 then port 1 in RUN.
  always_comb begin
    logic [DATA_WIDTH-1:0] ovl0_v;
    logic [DATA_WIDTH-1:0] ovl1_v;
    ovl0_v = DATA_ZERO;
    ovl1_v = DATA_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      ovl0_v = (wr0_live_s && (wr0_addr == ADDR_WIDTH'(i)))
             ? lane_merge(mem_r[i], wr0_data, mask0_s) : mem_r[i];
      ovl1_v = (wr1_live_s && (wr1_addr == ADDR_WIDTH'(i)))
             ? lane_merge(ovl0_v, wr1_data, mask1_s) : ovl0_v;
      if (i == 0) begin
        mem_nxt_s[i] = DATA_ZERO;
      end else if (run_s) begin
        mem_nxt_s[i] = ovl1_v;
      end else begin
        mem_nxt_s[i] = (ptr_r == ADDR_WIDTH'(i)) ? DATA_ZERO : mem_r[i];
      end
    end
  end

  // Register storage (no reset; the clear engine zeroes it).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_r[i] <= mem_nxt_s[i];
    end
  end

  // Scoreboard next state: writes clear, an issue sets, set beats clear.
  always_comb begin
    pend_nxt_s = {DEPTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      pend_nxt_s[i] = (set_live_s && (sb_set_addr == ADDR_WIDTH'(i)))
                    | (pend_r[i]
                       & ~(wr0_live_s && (wr0_addr == ADDR_WIDTH'(i)))
                       & ~(wr1_live_s && (wr1_addr == ADDR_WIDTH'(i))));
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Read ports: stored value overlaid with this cycle's writes. The pending
  // bit is hidden when a write to the same register lands this cycle.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a_v;
    logic                  m0_v, m1_v;
    logic [DATA_WIDTH-1:0] d0_v, d1_v;
    rd_data_s    = {(NUM_RD*DATA_WIDTH){1'b0}};
    rd_pending_s = {NUM_RD{1'b0}};
    a_v  = ADDR_ZERO;
    m0_v = 1'b0;
    m1_v = 1'b0;
    d0_v = DATA_ZERO;
    d1_v = DATA_ZERO;
    for (int k = 0; k < NUM_RD; k++) begin
      a_v  = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      m0_v = wr0_live_s && (wr0_addr == a_v);
      m1_v = wr1_live_s && (wr1_addr == a_v);
      d0_v = m0_v ? lane_merge(mem_r[a_v], wr0_data, mask0_s) : mem_r[a_v];
      d1_v = m1_v ? lane_merge(d0_v, wr1_data, mask1_s) : d0_v;
      if (run_s && (a_v != ADDR_ZERO)) begin
        rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = d1_v;
        rd_pending_s[k] = pend_r[a_v] & ~(m0_v | m1_v);
      end else begin
        rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = DATA_ZERO;
        rd_pending_s[k] = 1'b0;
      end
    end
  end

  assign init_busy   = busy_r;
  assign pending_vec = pend_r;
  assign rd_data     = rd_data_s;
  assign rd_pending  = rd_pending_s;

endmodule

// File: tb/tb_vrf_multiport_sb.sv
// Self-checking bench for vrf_multiport_sb. It runs a directed sequence (clear
// engine, PPP lanes, dual-port merge, scoreboard, R0) followed by a random
// phase. Outputs are compared every cycle against an abstract model: an
// array of registers, an array of pending flags, and an init countdown.
module tb_vrf_multiport_sb;
  localparam int DEPTH = 32;
  localparam int W     = 64;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic             clk;
  logic             reset;
  logic             init_busy;
  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_addr, wr1_addr;
  logic [W-1:0]     wr0_data, wr1_data;
  logic [2:0]       wr0_ppp, wr1_ppp;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*W-1:0] rd_data;
  logic [NRD-1:0]   rd_pending;
  logic             sb_set_en;
  logic [AW-1:0]    sb_set_addr;
  logic [DEPTH-1:0] pending_vec;

  vrf_multiport_sb #(.DEPTH(DEPTH), .DATA_WIDTH(W), .NUM_RD(NRD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ppp(wr0_ppp),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ppp(wr1_ppp),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pending_vec(pending_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] m_mem  [DEPTH];
  bit           m_pend [DEPTH];
  bit           m_init;
  int           m_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Is big-endian lane bit i selected by PPP code ppp?
  function automatic bit in_mask(input logic [2:0] ppp, input int i);
    case (ppp)
      3'd0:    return 1'b1;
      3'd1:    return i < W/2;
      3'd2:    return i >= W/2;
      3'd3:    return ((i / 8) % 2) == 0;
      3'd4:    return ((i / 8) % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] apply(input logic [W-1:0] base, input logic [W-1:0] data,
                                         input logic [2:0] ppp);
    logic [W-1:0] r;
    r = base;
    for (int i = 0; i < W; i++)
      if (in_mask(ppp, i)) r[W-1-i] = data[W-1-i];
    return r;
  endfunction

  function automatic bit live(input logic en, input logic [AW-1:0] a);
    return !reset && !m_init && en && (a != 0);
  endfunction

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
    logic [W-1:0] r;
    if (m_init || a == 0) return '0;
    r = m_mem[a];
    if (live(wr0_en, wr0_addr) && wr0_addr == a) r = apply(r, wr0_data, wr0_ppp);
    if (live(wr1_en, wr1_addr) && wr1_addr == a) r = apply(r, wr1_data, wr1_ppp);
    return r;
  endfunction

  function automatic bit exp_rdpend(input logic [AW-1:0] a);
    if (m_init || a == 0) return 1'b0;
    return m_pend[a] && !(live(wr0_en, wr0_addr) && wr0_addr == a)
                     && !(live(wr1_en, wr1_addr) && wr1_addr == a);
  endfunction

  task automatic check_all(input string tag);
    logic [DEPTH-1:0] pv;
    logic [AW-1:0]    a;
    for (int i = 0; i < DEPTH; i++) pv[i] = m_pend[i];
    chk({tag, ".busy"}, 64'(init_busy), 64'(m_init));
    chk({tag, ".pvec"}, 64'(pending_vec), 64'(pv));
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      chk($sformatf("%s.rd%0d", tag, k), rd_data[k*W +: W], exp_read(a));
      chk($sformatf("%s.rp%0d", tag, k), 64'(rd_pending[k]), 64'(exp_rdpend(a)));
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic commit();
    bit l0, l1, ls;
    l0 = live(wr0_en, wr0_addr);
    l1 = live(wr1_en, wr1_addr);
    ls = live(sb_set_en, sb_set_addr);
    if (reset) begin
      m_init = 1'b1;
      m_left = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    end else if (m_init) begin
      m_left--;
      if (m_left == 0) begin
        m_init = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      if (l0) m_mem[wr0_addr] = apply(m_mem[wr0_addr], wr0_data, wr0_ppp);
      if (l1) m_mem[wr1_addr] = apply(m_mem[wr1_addr], wr1_data, wr1_ppp);
      if (l0) m_pend[wr0_addr] = 1'b0;
      if (l1) m_pend[wr1_addr] = 1'b0;
      if (ls) m_pend[sb_set_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_ppp = 3'd0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_ppp = 3'd0;
    rd_addr = '0; sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  // Check settled outputs, cross the clock edge, and return at the negedge.
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic count_init(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (init_busy !== 1'b1) break;
      cnt++;
      tick(tag);
      idle();
      set_rd(0, 5'd5);
    end
    chk({tag, ".len"}, 64'(cnt), 64'd31);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    commit();
    @(negedge clk);
    #1;
    chk("rst.busy", 64'(init_busy), 64'd1);
    chk("rst.pvec", 64'(pending_vec), 64'd0);
    chk("rst.rd0", rd_data[63:0], 64'd0);
    chk("rst.rp", 64'(rd_pending), 64'd0);

    // Clear engine; a write during INIT must be dropped
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'hFFFF_FFFF_FFFF_FFFF; wr0_ppp = 3'd0;
    set_rd(0, 5'd5);
    count_init("init1");
    idle();
    set_rd(0, 5'd5);
    #1 chk("r5_after_init", rd_data[63:0], 64'd0);
    tick("r5");

    // Reset again partway through INIT
    reset = 1'b1;
    tick("rst2");
    idle();
    for (int i = 0; i < 10; i++) tick("init2");
    reset = 1'b1;
    tick("rst3");
    idle();
    count_init("init3");
    idle();

    // Even-byte lane write on R3
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h1111_1111_1111_1111; wr0_ppp = 3'd0;
    tick("r3_fill");
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'hAAAA_AAAA_AAAA_AAAA; wr0_ppp = 3'b011;
    set_rd(0, 5'd3);
    #1 chk("r3_even_bypass", rd_data[63:0], 64'hAA11_AA11_AA11_AA11);
    tick("r3_even");
    idle();
    set_rd(0, 5'd3);
    #1 chk("r3_even_stored", rd_data[63:0], 64'hAA11_AA11_AA11_AA11);
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h5555_5555_5555_5555; wr0_ppp = 3'b110;
    #1 chk("r3_empty_bypass", rd_data[63:0], 64'hAA11_AA11_AA11_AA11);
    tick("r3_empty");
    idle();
    set_rd(0, 5'd3);
    #1 chk("r3_empty_stored", rd_data[63:0], 64'hAA11_AA11_AA11_AA11);

    // Both ports to R7: port 1 d-mode over port 0 a-mode
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'hFFFF_FFFF_FFFF_FFFF; wr0_ppp = 3'd0;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'd0;                  wr1_ppp = 3'b010;
    set_rd(1, 5'd7);
    #1 chk("r7_merge_bypass", rd_data[127:64], 64'hFFFF_FFFF_0000_0000);
    tick("r7_merge");
    idle();
    set_rd(1, 5'd7);
    #1 chk("r7_merge_stored", rd_data[127:64], 64'hFFFF_FFFF_0000_0000);

    // Scoreboard on R9
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    tick("r9_set");
    idle();
    set_rd(2, 5'd9);
    #1 chk("r9_pvec_set", 64'(pending_vec[9]), 64'd1);
    chk("r9_rp_set", 64'(rd_pending[2]), 64'd1);
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h123; wr0_ppp = 3'd0;
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    #1 chk("r9_rp_wrset", 64'(rd_pending[2]), 64'd0);
    tick("r9_wrset");
    idle();
    set_rd(2, 5'd9);
    #1 chk("r9_pvec_setwins", 64'(pending_vec[9]), 64'd1);
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'hDEAD; wr1_ppp = 3'b111;
    #1 chk("r9_rp_wr", 64'(rd_pending[2]), 64'd0);
    chk("r9_empty_nobypass", rd_data[191:128], 64'h123);
    tick("r9_wr");
    idle();
    #1 chk("r9_pvec_clr", 64'(pending_vec[9]), 64'd0);

    // R0 stays zero and never pending
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hDEAD_BEEF_DEAD_BEEF; wr0_ppp = 3'd0;
    set_rd(0, 5'd0);
    #1 chk("r0_bypass", rd_data[63:0], 64'd0);
    tick("r0_wr");
    idle();
    set_rd(0, 5'd0);
    #1 chk("r0_stored", rd_data[63:0], 64'd0);
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    tick("r0_set");
    idle();
    #1 chk("r0_pvec", 64'(pending_vec[0]), 64'd0);

    // Random phase with collisions concentrated on a few registers
    for (int n = 0; n < 500; n++) begin
      idle();
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
      end else begin
        wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 5'($urandom_range(0, 7));
        wr0_data = {$urandom(), $urandom()}; wr0_ppp = 3'($urandom_range(0, 7));
        wr1_en = 1'($urandom_range(0, 1)); wr1_addr = 5'($urandom_range(0, 7));
        wr1_data = {$urandom(), $urandom()}; wr1_ppp = 3'($urandom_range(0, 7));
        sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = 5'($urandom_range(0, 7));
        set_rd(0, wr0_addr);
        set_rd(1, wr1_addr);
        set_rd(2, 5'($urandom_range(0, 31)));
      end
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
